// File: rtl/conv16_sched_pkg.sv
// Shared types and elaboration helpers for the conv16 layer sequencer.
package conv16_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  // Output map edge length for a valid (no padding) convolution.
  function automatic int unsigned out_dim(input int unsigned map_size,
                                          input int unsigned k);
    return map_size - k + 1;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // True when a field of the given width can index count distinct items.
  function automatic bit width_ok(input int unsigned width,
                                  input int unsigned count);
    return width >= $clog2(count);
  endfunction

endpackage

// File: rtl/conv16_sched_raster_cnt.sv
// Row/column raster counter over a MAP_SIZE x MAP_SIZE map. Saturates at the
// last pixel; flags the last pixel and pixels that complete a KxK window.
module raster_cnt
  import conv16_sched_pkg::*;
#(
  parameter int unsigned MAP_SIZE = 7,
  parameter int unsigned K        = 5,
  parameter int unsigned CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last,
  output logic          win
);

  localparam logic [CW-1:0] MAXP = CW'(MAP_SIZE - 1);
  localparam logic [CW-1:0] KM1  = CW'(K - 1);

  logic [CW-1:0] row_q, row_d, col_q, col_d;

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == MAXP) && (col_q == MAXP);
  assign win  = (row_q >= KM1) && (col_q >= KM1);

  // Advance in raster order; clear has priority over enable.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en && !last) begin
      if (col_q == MAXP) begin
        col_d = '0;
        row_d = row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/conv16_sched.sv
// Layer-pass sequencer: per filter, clears the window, streams the input
// buffer in raster order and tags each completed window with row/col/filter
// under a valid/ready handshake that freezes the whole pipeline when stalled.
module conv16_sched
  import conv16_sched_pkg::*;
#(
  parameter int MAP_SIZE    = 7,
  parameter int K           = 5,
  parameter int NUM_FILTERS = 16,
  parameter int ADDR_WIDTH  = 6,
  parameter int FILT_WIDTH  = 4,
  parameter int POS_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  conv_en,
  output logic                  conv_rst,
  output logic [FILT_WIDTH-1:0] filt_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [POS_WIDTH-1:0]  out_row,
  output logic [POS_WIDTH-1:0]  out_col,
  output logic [FILT_WIDTH-1:0] out_filt
);

  localparam int unsigned           CW        = bits_for(MAP_SIZE);
  localparam logic [CW-1:0]         KM1       = CW'(K - 1);
  localparam logic [FILT_WIDTH-1:0] LAST_FILT = FILT_WIDTH'(NUM_FILTERS - 1);

  if (!width_ok(ADDR_WIDTH, MAP_SIZE * MAP_SIZE)) begin : g_bad_addr
    $error("ADDR_WIDTH too small for MAP_SIZE");
  end
  if (!width_ok(FILT_WIDTH, NUM_FILTERS)) begin : g_bad_filt
    $error("FILT_WIDTH too small for NUM_FILTERS");
  end
  if (!width_ok(POS_WIDTH, out_dim(MAP_SIZE, K))) begin : g_bad_pos
    $error("POS_WIDTH too small for output map");
  end

  state_e                state_q, state_d;
  logic [FILT_WIDTH-1:0] filt_q, filt_d;
  logic                  pend_q, pend_d;
  logic                  ov_q, ov_d;
  logic                  olast_q, olast_d;
  logic [POS_WIDTH-1:0]  orow_q, orow_d, ocol_q, ocol_d;
  logic [FILT_WIDTH-1:0] ofilt_q, ofilt_d;

  logic          stall, rd, shift, clr;
  logic [CW-1:0] iss_row, iss_col, sh_row, sh_col;
  logic          iss_last, iss_win_unused, sh_last, sh_win;

  assign stall = ov_q && !out_ready;
  assign shift = pend_q && !stall;

  raster_cnt #(.MAP_SIZE(MAP_SIZE), .K(K), .CW(CW)) u_iss (
    .clk(clk), .rst(rst), .clr(clr), .en(rd),
    .row(iss_row), .col(iss_col), .last(iss_last), .win(iss_win_unused)
  );

  raster_cnt #(.MAP_SIZE(MAP_SIZE), .K(K), .CW(CW)) u_shift (
    .clk(clk), .rst(rst), .clr(clr), .en(shift),
    .row(sh_row), .col(sh_col), .last(sh_last), .win(sh_win)
  );

  assign mem_addr  = ADDR_WIDTH'(32'(iss_row) * MAP_SIZE + 32'(iss_col));
  assign conv_en   = shift;
  assign filt_sel  = filt_q;
  assign out_valid = ov_q;
  assign out_row   = orow_q;
  assign out_col   = ocol_q;
  assign out_filt  = ofilt_q;

  // State and filter index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      filt_q  <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
    end
  end

  // Next state; a filter ends when its last-pixel output handshakes.
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          filt_d  = '0;
        end
      end
      CLEAR:  state_d = STREAM;
      STREAM: if (rd && iss_last) state_d = DRAIN;
      DRAIN: begin
        if (ov_q && olast_q && out_ready) begin
          if (filt_q != LAST_FILT) begin
            filt_d  = filt_q + FILT_WIDTH'(1);
            state_d = CLEAR;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; reads are suppressed while the output is stalled.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    conv_rst = (state_q == CLEAR);
    clr      = (state_q == CLEAR);
    rd       = (state_q == STREAM) && !stall;
    mem_rd   = rd;
  end

  // Read-to-shift and shift-to-output stages; everything holds while stalled,
  // so a pending shift resumes on the first unstalled cycle.
  always_comb begin
    pend_d  = pend_q;
    ov_d    = ov_q;
    olast_d = olast_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    ofilt_d = ofilt_q;
    if (!stall) begin
      pend_d  = rd;
      ov_d    = shift && sh_win;
      olast_d = shift && sh_last;
      if (shift && sh_win) begin
        orow_d  = POS_WIDTH'(sh_row - KM1);
        ocol_d  = POS_WIDTH'(sh_col - KM1);
        ofilt_d = filt_q;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      ov_q    <= 1'b0;
      olast_q <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
      ofilt_q <= '0;
    end else begin
      pend_q  <= pend_d;
      ov_q    <= ov_d;
      olast_q <= olast_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      ofilt_q <= ofilt_d;
    end
  end

endmodule

// File: tb/tb_conv16_sched.sv
// Directed bench for conv16_sched: nominal pass, start-while-busy,
// backpressure, random ready, mid-pass reset and a 5x5 single-output map.
module tb_conv16_sched;

  typedef struct {
    int cyc;
    int row;
    int col;
    int filt;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, out_ready;
  logic       busy, done, mem_rd, conv_en, conv_rst, out_valid;
  logic [5:0] mem_addr;
  logic [3:0] filt_sel, out_filt;
  logic [2:0] out_row, out_col;

  logic       rst5, start5, ready5;
  logic       busy5, done5, mem_rd5, conv_en5, conv_rst5, out_valid5;
  logic [5:0] mem_addr5;
  logic [3:0] filt_sel5, out_filt5;
  logic [2:0] out_row5, out_col5;

  conv16_sched #(.MAP_SIZE(7), .K(5), .NUM_FILTERS(2), .ADDR_WIDTH(6),
                 .FILT_WIDTH(4), .POS_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .conv_en(conv_en),
    .conv_rst(conv_rst), .filt_sel(filt_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
    .out_filt(out_filt)
  );

  conv16_sched #(.MAP_SIZE(5), .K(5), .NUM_FILTERS(1), .ADDR_WIDTH(6),
                 .FILT_WIDTH(4), .POS_WIDTH(3)) dut5 (
    .clk(clk), .rst(rst5), .start(start5), .busy(busy5), .done(done5),
    .mem_rd(mem_rd5), .mem_addr(mem_addr5), .conv_en(conv_en5),
    .conv_rst(conv_rst5), .filt_sel(filt_sel5), .out_valid(out_valid5),
    .out_ready(ready5), .out_row(out_row5), .out_col(out_col5),
    .out_filt(out_filt5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  ev_t  exp_tab[18];
  ev_t  got[$];
  int   done_cyc, done_cnt, cen_cnt, rd_cnt, ovl_cnt, stall_err, stall_cnt;
  int   busy_cyc, clr_cyc, rd_first;
  logic [25:0] probe_vec;
  bit         prev_stall;
  logic [2:0] prev_row, prev_col;
  logic [3:0] prev_filt;

  wire [25:0] outvec = {busy, done, mem_rd, mem_addr, conv_en, conv_rst,
                        filt_sel, out_valid, out_row, out_col, out_filt};

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pack(input ev_t e);
    return e.cyc * 10000 + e.row * 1000 + e.col * 100 + e.filt;
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 1) return !(cyc >= 36 && cyc <= 38);
    if (mode == 2) return logic'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic sample(input int cyc);
    ev_t e;
    if (out_valid && out_ready) begin
      e.cyc = cyc; e.row = int'(out_row); e.col = int'(out_col); e.filt = int'(out_filt);
      got.push_back(e);
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (conv_en) cen_cnt++;
    if (mem_rd) begin
      rd_cnt++;
      if (rd_first < 0) rd_first = cyc;
    end
    if (conv_en && conv_rst) ovl_cnt++;
    if (conv_rst && clr_cyc < 0) clr_cyc = cyc;
    if (busy && busy_cyc < 0) busy_cyc = cyc;
    if (out_valid && !out_ready) begin
      stall_cnt++;
      if (mem_rd || conv_en) stall_err++;
    end
    if (prev_stall && !(out_valid && out_row == prev_row &&
                        out_col == prev_col && out_filt == prev_filt))
      stall_err++;
    prev_stall = out_valid && !out_ready;
    prev_row   = out_row;
    prev_col   = out_col;
    prev_filt  = out_filt;
    if (cyc == 21) probe_vec = outvec;
  endtask

  // mode: 0 ready always, 1 ready low in cycles 36..38, 2 random ready.
  task automatic run_pass(input int mode, input int extra_start,
                          input int rst_at, input int limit);
    int cyc;
    got.delete();
    done_cyc = -1; done_cnt = 0; cen_cnt = 0; rd_cnt = 0; ovl_cnt = 0;
    stall_err = 0; stall_cnt = 0; busy_cyc = -1; clr_cyc = -1; rd_first = -1;
    prev_stall = 1'b0; probe_vec = '1;
    @(posedge clk); #1;
    cyc = 0;
    start = 1'b1;
    rst = 1'b0;
    out_ready = ready_for(mode, 0);
    forever begin
      @(negedge clk);
      sample(cyc);
      if (cyc >= limit || (done_cyc >= 0 && cyc >= done_cyc + 2)) break;
      @(posedge clk); #1;
      cyc++;
      start = (cyc == extra_start);
      rst = (cyc == rst_at);
      out_ready = ready_for(mode, cyc);
    end
    start = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic compare_tab(input string tag, input int shift, input bit with_cyc);
    check({tag, "_n_outputs"}, got.size(), 18);
    for (int i = 0; i < 18; i++) begin
      ev_t e;
      ev_t g;
      e = exp_tab[i];
      e.cyc = with_cyc ? e.cyc + shift : 0;
      if (i < got.size()) begin
        g = got[i];
        if (!with_cyc) g.cyc = 0;
      end else begin
        g.cyc = -1; g.row = -1; g.col = -1; g.filt = -1;
      end
      check($sformatf("%s_out%0d", tag, i), pack(g), pack(e));
    end
  endtask

  initial begin
    int first5, pos5, cnt5, d5;

    // Outputs land 36 + 7*row + col cycles after start, 52 cycles per filter.
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          exp_tab[f * 9 + r * 3 + c] = '{36 + 52 * f + 7 * r + c, r, c, f};

    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    rst5 = 1'b1; start5 = 1'b0; ready5 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", longint'(outvec), 0);
    check("reset_outputs5", longint'({busy5, done5, mem_rd5, conv_en5, conv_rst5,
                                      out_valid5, filt_sel5}), 0);
    @(posedge clk); #1;
    rst = 1'b0; rst5 = 1'b0;
    repeat (2) @(posedge clk);

    // Nominal two-filter pass.
    run_pass(0, -1, -1, 400);
    check("nom_busy_rise", busy_cyc, 1);
    check("nom_clear_cyc", clr_cyc, 1);
    check("nom_first_rd", rd_first, 2);
    check("nom_rd_count", rd_cnt, 98);
    check("nom_conv_en_count", cen_cnt, 98);
    check("nom_rst_en_overlap", ovl_cnt, 0);
    check("nom_done_cyc", done_cyc, 105);
    check("nom_done_count", done_cnt, 1);
    compare_tab("nom", 0, 1'b1);

    // Second start while busy must be ignored.
    run_pass(0, 10, -1, 400);
    check("busy_start_done_cyc", done_cyc, 105);
    check("busy_start_done_count", done_cnt, 1);
    compare_tab("busy_start", 0, 1'b1);

    // Three stall cycles at the first output.
    run_pass(1, -1, -1, 400);
    check("bp_stall_cycles", stall_cnt, 3);
    check("bp_stall_violations", stall_err, 0);
    check("bp_conv_en_count", cen_cnt, 98);
    check("bp_done_cyc", done_cyc, 108);
    compare_tab("bp", 3, 1'b1);

    // Random ready: order and content only.
    run_pass(2, -1, -1, 2000);
    check("rnd_stall_violations", stall_err, 0);
    check("rnd_conv_en_count", cen_cnt, 98);
    check("rnd_rst_en_overlap", ovl_cnt, 0);
    check("rnd_done_count", done_cnt, 1);
    compare_tab("rnd", 0, 1'b0);

    // Reset in cycle 20 aborts with no done, then a clean pass.
    run_pass(0, -1, 20, 150);
    check("midrst_outputs", longint'(probe_vec), 0);
    check("midrst_done_count", done_cnt, 0);
    run_pass(0, -1, -1, 400);
    check("after_rst_done_cyc", done_cyc, 105);
    compare_tab("after_rst", 0, 1'b1);

    // 5x5 map, single window, single filter.
    first5 = -1; pos5 = -1; cnt5 = 0; d5 = -1;
    @(posedge clk); #1;
    start5 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid5 && ready5) begin
        cnt5++;
        if (first5 < 0) begin
          first5 = k;
          pos5 = int'(out_row5) * 100 + int'(out_col5) * 10 + int'(out_filt5);
        end
      end
      if (done5 && d5 < 0) d5 = k;
      @(posedge clk); #1;
      start5 = 1'b0;
    end
    check("map5_first_out_cyc", first5, 28);
    check("map5_first_out_pos", pos5, 0);
    check("map5_out_count", cnt5, 1);
    check("map5_done_cyc", d5, 29);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv16_sched.md
# conv16_sched

Sequencer for the 16-channel 5x5 convolution datapath. It handles one layer pass for NUM_FILTERS output filters, one filter at a time. For each filter it clears the window, selects the filter, and streams every pixel of a MAP_SIZE x MAP_SIZE, 16-channel input buffer into the convolution in raster order. It marks each cycle in which the datapath's sum is a valid output and tags that output with its row, column and filter, under a valid/ready handshake to the output writer.

## Interface
Parameters:
- MAP_SIZE, 7: input map height/width in pixels.
- K, 5: kernel size; OUT_DIM = MAP_SIZE-K+1.
- NUM_FILTERS, 16: output filters per pass.
- ADDR_WIDTH, 6: input buffer address width; must be >= clog2(MAP_SIZE*MAP_SIZE).
- FILT_WIDTH, 4: filter index width; must be >= clog2(NUM_FILTERS).
- POS_WIDTH, 3: width of out_row/out_col; must be >= clog2(OUT_DIM).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at pass end.
- mem_rd  out  1  input buffer read strobe.
- mem_addr  out  ADDR_WIDTH  pixel address, row-major (r*MAP_SIZE+c).
- conv_en  out  1  shift one pixel into the convolution window.
- conv_rst  out  1  clear the convolution window.
- filt_sel  out  FILT_WIDTH  current filter index, drives the filter/bias muxes.
- out_valid  out  1  convValue is a valid output this cycle.
- out_ready  in  1  output writer accepts.
- out_row, out_col  out  POS_WIDTH  output position.
- out_filt  out  FILT_WIDTH  filter of the current output.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: waits for start. start -> CLEAR, with filt_sel=0. start is ignored in every other state.
- CLEAR: lasts 1 cycle. conv_rst=1 and the pixel counter is set to 0. Next state is STREAM.
- STREAM:
  - mem_rd=1 and mem_addr = pixel counter; the counter increments on every unstalled cycle.
  - After address MAP_SIZE^2-1 is issued, next state is DRAIN.
- conv_en is mem_rd delayed one cycle. The buffer returns data one cycle after mem_rd and holds its read data while mem_rd=0.
- A pixel (r,c) shifted in by conv_en completes a window when r>=K-1 and c>=K-1. out_valid is then asserted the following cycle with out_row=r-K+1, out_col=c-K+1, out_filt=filt_sel.
- DRAIN: waits until the last conv_en has issued and the last output has handshaken.
  - If filt_sel < NUM_FILTERS-1: filt_sel+1 and go to CLEAR.
  - Otherwise go to DONE.
- DONE: lasts 1 cycle with done=1. Next state is IDLE. busy=0 in IDLE.
- Stall: while out_valid=1 and out_ready=0:
  - mem_rd=0 and conv_en=0;
  - all counters and state are frozen;
  - out_valid and out_row/out_col/out_filt stay stable.
  - The pending conv_en is released in the cycle after the handshake.
- Handshake completes when out_valid && out_ready in the same cycle.
- Reset values: every output 0 and state IDLE. Reset mid-pass aborts immediately, with no done pulse.
- Counter wrap: the column resets to 0 at MAP_SIZE-1 and the row increments. No counter wraps past MAP_SIZE^2-1.

## Timing
- Measured from start high in cycle 0 with out_ready held at 1:
  - CLEAR in cycle 1;
  - mem_rd in cycles 2..MAP_SIZE^2+1;
  - conv_en for pixel p in cycle 3+p;
  - out_valid for pixel p in cycle 4+p.
- The last output of a filter is in cycle MAP_SIZE^2+3. The next CLEAR, or DONE, follows in the next cycle.
- Each filter takes MAP_SIZE^2+3 cycles. done is asserted at cycle NUM_FILTERS*(MAP_SIZE^2+3)+1.
- Every stall cycle adds exactly one cycle to all later events.
- conv_rst and conv_en are never high in the same cycle.

## Structure
- Package conv16_sched_pkg holds:
  - the state enum (IDLE, CLEAR, STREAM, DRAIN, DONE);
  - a helper function for OUT_DIM;
  - width-check functions.
- Sub-module raster_cnt is a row/column counter with enable, clear, last-pixel flag and window-complete flag. It is instantiated twice:
  - once on the issue side (mem_addr);
  - once on the shift side (conv_en), which produces out_row/out_col.

## Test plan
- Nominal pass, MAP_SIZE=7, K=5, NUM_FILTERS=2, out_ready=1, start at cycle 0:
  - out_valid first in cycle 36 with (0,0,f0);
  - outputs 9 per filter, in raster order;
  - last output (2,2,f1) in cycle 104;
  - done in cycle 105.
- Backpressure: out_ready=0 for 3 cycles at the first output:
  - out_valid and position stay stable;
  - mem_rd and conv_en stay low;
  - all later events shift by 3; done in cycle 108.
- Random out_ready at 50%: the scoreboard gets 9*NUM_FILTERS outputs, none duplicated or missing, and conv_en pulses equal NUM_FILTERS*49.
- Reset mid-STREAM (cycle 20): all outputs are 0 next cycle with no done pulse. A new start then runs a full, correct pass.
- Start while busy (cycle 10): ignored; the timing matches the nominal pass.
- Degenerate MAP_SIZE=5, K=5, NUM_FILTERS=1: one output (0,0,0) in cycle 28; done in cycle 29.
